seq_mac_neuron: RTL and testbench



---
 rtl/neuron_pkg.sv | 30 +++
 rtl/neuron_activate.sv | 41 ++++
 rtl/seq_mac_neuron.sv | 107 ++++++++++
 tb/tb_seq_mac_neuron.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, constants and clipping helper for the neuron datapath blocks.
package neuron_pkg;

  typedef enum logic [1:0] {
    RELU  = 2'd0,
    IDENT = 2'd1,
    LEAKY = 2'd2
  } act_mode_e;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUT    = 2'd2
  } neuron_state_e;

  localparam int LEAKY_SHIFT = 3;

  // Saturate a signed value (up to 64 bits) into a signed range of 'width' bits.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/neuron_activate.sv
// Combinational clip to DATA_W followed by the selected activation.
// NEURON_SAT_EN selects saturating clip; otherwise the low DATA_W bits are kept.
module neuron_activate
  import neuron_pkg::*;
#(
  parameter int        IN_W     = 32,
  parameter int        DATA_W   = 16,
  parameter act_mode_e ACT_MODE = RELU
) (
  input  logic signed [IN_W-1:0]   value,
  output logic signed [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] clipped;
  logic                     unused_bits;

`ifdef NEURON_SAT_EN
  logic signed [63:0] sat_full;

  always_comb begin
    sat_full = sat_clip(64'(value), DATA_W);
    clipped  = sat_full[DATA_W-1:0];
  end

  assign unused_bits = ^sat_full;
`else
  always_comb clipped = value[DATA_W-1:0];

  assign unused_bits = ^value;
`endif

  always_comb begin
    result = clipped;
    case (ACT_MODE)
      RELU:    if (clipped < 0) result = '0;
      LEAKY:   if (clipped < 0) result = clipped >>> LEAKY_SHIFT;
      default: result = clipped;
    endcase
  end

endmodule

// File: rtl/seq_mac_neuron.sv
// Sequential neuron: one multiply-accumulate per accepted beat, then rescale,
// clip and activate. Define NEURON_SAT_EN for a saturating clip.
module seq_mac_neuron
  import neuron_pkg::*;
#(
  parameter int                       INPUT_COUNT = 4,
  parameter int                       DATA_W      = 16,
  parameter int                       FRAC_BITS   = 8,
  parameter int                       ACC_W       = 40,
  parameter logic signed [DATA_W-1:0] WEIGHTS [INPUT_COUNT] = '{default: '0},
  parameter logic signed [DATA_W-1:0] BIAS        = '0,
  parameter int                       ACT_MODE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     err_len
);

  localparam int IDX_W  = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] ACC_INIT = ACC_W'(BIAS) <<< FRAC_BITS;

  neuron_state_e            state;
  neuron_state_e            state_next;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_scaled;
  logic signed [DATA_W-1:0] act_result;
  logic                     at_end;

  assign at_end = (idx == IDX_W'(INPUT_COUNT - 1));

  always_comb prod = PROD_W'(in_data) * PROD_W'(WEIGHTS[idx]);

  always_comb acc_scaled = acc >>> FRAC_BITS;

  neuron_activate #(
    .IN_W    (ACC_W),
    .DATA_W  (DATA_W),
    .ACT_MODE(act_mode_e'(ACT_MODE))
  ) u_activate (
    .value (acc_scaled),
    .result(act_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || at_end)) state_next = FINISH;
      end
      FINISH:  state_next = OUT;
      OUT:     if (out_ready) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Accumulate on accepted beats; FINISH registers the activated result.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      acc       <= ACC_INIT;
      out_data  <= '0;
      out_valid <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc + ACC_W'(prod);
            idx <= idx + 1'b1;
            if (in_last || at_end) err_len <= (in_last != at_end);
          end
        end
        FINISH: begin
          out_data  <= act_result;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= ACC_INIT;
            idx       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_neuron.sv
// Scoreboard bench: three neurons (ReLU, identity, leaky) share one input stream.
module tb_seq_mac_neuron;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_rdy [3];
  logic               out_vld [3];
  logic signed [15:0] out_dat [3];
  logic               err [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic signed [15:0] r0;
    logic signed [15:0] r1;
    logic signed [15:0] r2;
  } exp_t;

  exp_t exp_q[$];

  logic hold = 1'b0;
  logic final_beat = 1'b0;
  logic cur_err = 1'b0;

  int   accept_cyc = -100;
  logic fin_pending = 1'b0;
  logic fin_err = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [47:0] held = '0;

  longint weights [4] = '{256, 512, -256, 128};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mac_neuron #(.INPUT_COUNT(4), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40),
    .WEIGHTS('{16'sd256, 16'sd512, -16'sd256, 16'sd128}), .BIAS(16'sd0), .ACT_MODE(0)
  ) dut_relu (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_vld[0]), .out_ready(out_ready),
    .out_data(out_dat[0]), .err_len(err[0]));

  seq_mac_neuron #(.INPUT_COUNT(4), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40),
    .WEIGHTS('{16'sd256, 16'sd512, -16'sd256, 16'sd128}), .BIAS(16'sd0), .ACT_MODE(1)
  ) dut_ident (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_vld[1]), .out_ready(out_ready),
    .out_data(out_dat[1]), .err_len(err[1]));

  seq_mac_neuron #(.INPUT_COUNT(4), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40),
    .WEIGHTS('{16'sd256, 16'sd512, -16'sd256, 16'sd128}), .BIAS(16'sd0), .ACT_MODE(2)
  ) dut_leaky (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .in_data(in_data), .in_last(in_last), .out_valid(out_vld[2]), .out_ready(out_ready),
    .out_data(out_dat[2]), .err_len(err[2]));

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: real-valued neuron on the beats received, Q8 rescale, clip, activation.
  function automatic longint ref_out(input longint sum, input int mode);
    longint r;
    longint c;
    logic [63:0] rb;
    r = sum >>> 8;
`ifdef NEURON_SAT_EN
    c = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
`else
    rb = r;
    c = longint'($signed(rb[15:0]));
`endif
    case (mode)
      0:       return (c < 0) ? 0 : c;
      2:       return (c < 0) ? (c >>> 3) : c;
      default: return c;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      fin_pending = 1'b0;
      prev_valid  = 1'b0;
      prev_ready  = 1'b0;
    end else begin
      if (fin_pending && cyc == accept_cyc + 1) begin
        check("err_len_relu", longint'(err[0]), longint'(fin_err));
        check("err_len_leaky", longint'(err[2]), longint'(fin_err));
        fin_pending = 1'b0;
      end else if (err[0] || err[1] || err[2]) begin
        check("err_len_spurious", 1, 0);
      end
      if (out_vld[0] && !prev_valid)
        check("latency", longint'(cyc - accept_cyc), 2);
      if (out_vld[0] && prev_valid && !prev_ready)
        check("hold_data", longint'({out_dat[0], out_dat[1], out_dat[2]}), longint'(held));
      if (out_vld[0])
        check("in_ready_while_out", longint'(in_rdy[0]), 0);
      if (out_vld[0] && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_relu", longint'(out_dat[0]), longint'(e.r0));
          check("out_ident", longint'(out_dat[1]), longint'(e.r1));
          check("out_leaky", longint'(out_dat[2]), longint'(e.r2));
        end
      end
      if (in_valid && in_rdy[0] && final_beat) begin
        accept_cyc  = cyc;
        fin_pending = 1'b1;
        fin_err     = cur_err;
      end
      prev_valid = out_vld[0];
      prev_ready = out_ready;
      held       = {out_dat[0], out_dat[1], out_dat[2]};
    end
  end

  task automatic send_beat(input logic signed [15:0] d, input logic l, input logic fin);
    bit ok;
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk) #1;
    in_valid = 1'b1; in_data = d; in_last = l; final_beat = fin;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_rdy[0]) begin ok = 1'b1; break; end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; final_beat = 1'b0;
  endtask

  // last_idx 0..3 places in_last on that beat; 4 means no in_last (4 beats sent).
  task automatic send_vec(input int d[4], input int last_idx);
    int nb;
    longint sum;
    exp_t e;
    nb = (last_idx < 4) ? last_idx + 1 : 4;
    sum = 0;
    for (int b = 0; b < nb; b++) sum += longint'(d[b]) * weights[b];
    e.r0 = 16'(ref_out(sum, 0));
    e.r1 = 16'(ref_out(sum, 1));
    e.r2 = 16'(ref_out(sum, 2));
    exp_q.push_back(e);
    cur_err = (last_idx != 3);
    for (int b = 0; b < nb; b++)
      send_beat(16'(d[b]), (b == last_idx), (b == nb - 1));
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", longint'(in_rdy[0]), 1);
    check("rst_out_valid", longint'(out_vld[0]), 0);
    check("rst_out_data", longint'(out_dat[0]), 0);
    check("rst_err_len", longint'(err[0]), 0);
  endtask

  initial begin
    int v1[4] = '{256, 256, 256, 256};
    int v2[4] = '{0, 0, 256, 0};
    int v3[4] = '{32767, 32767, 0, 0};
    int rv[4];
    int li;
    bit ok;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    send_vec(v1, 3);
    send_vec(v2, 3);
    send_vec(v3, 3);
    drain();

    // Output held back for five cycles while the next beat waits upstream.
    hold = 1'b1;
    send_vec(v1, 3);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_vld[0]) begin ok = 1'b1; break; end
    end
    if (!ok) check("out_valid_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'sd1000; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_ready", longint'(in_rdy[0]), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    hold = 1'b0;

    send_vec(v1, 1);
    send_vec(v1, 3);
    drain();

    // Reset after two beats discards the partial vector.
    send_beat(16'sd256, 1'b0, 1'b0);
    send_beat(16'sd256, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    send_vec(v1, 3);

    for (int n = 0; n < 30; n++) begin
      for (int b = 0; b < 4; b++)
        rv[b] = ($urandom_range(0, 4) == 0) ? int'($signed(16'($urandom)))
                                            : int'($urandom_range(0, 4000)) - 2000;
      li = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(0, 4));
      send_vec(rv, li);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
